// File: rtl/mem_sync_pkg.sv
// mem_sync_pkg: shared types and encodings for the bank row-cache sync path
package mem_sync_pkg;
  localparam int BG_W = 2;
  localparam int BA_W = 2;
  typedef enum logic [2:0] {IDLE, WB, FILL, DONE, HOLD} sync_state_t;
  typedef logic [BG_W+BA_W-1:0] bank_t;
  localparam logic [4:0] BANK_ACT = 5'b00001;
  localparam logic [4:0] BANK_PRE = 5'b01010;
  localparam logic [4:0] BANK_RD  = 5'b01011;
  localparam logic [4:0] BANK_RDA = 5'b01100;
  localparam logic [4:0] BANK_WR  = 5'b10010;
  localparam logic [4:0] BANK_WRA = 5'b10011;
  function automatic bank_t bank_idx(input logic [BG_W-1:0] bg, input logic [BA_W-1:0] ba);
    return {bg, ba};
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin priority arbiter with a one-bank request mask
module rr_arbiter #(
  parameter int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         mask_en,
  input  logic [W-1:0] mask_idx,
  input  logic         advance,
  input  logic [W-1:0] adv_idx,
  output logic         gnt_valid,
  output logic [W-1:0] gnt
);
  logic [W-1:0] ptr;
  logic [W-1:0] idx;
  logic [N-1:0] eff;
  always_comb eff = req & ~(N'(mask_en) << mask_idx);
  // Scan from the farthest offset down so the nearest requester at/after ptr wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt = ptr;
    idx = ptr;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ptr + W'(i);
      if (eff[idx]) begin
        gnt_valid = 1'b1;
        gnt = idx;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) ptr <= '0;
    else if (advance) ptr <= adv_idx + W'(1);
  end
endmodule

// File: rtl/mem_sync_scheduler.sv
// mem_sync_scheduler: round-robin row transfer scheduler returning per-bank sync pulses
module mem_sync_scheduler
  import mem_sync_pkg::*;
#(
  parameter int BGWIDTH = BG_W,
  parameter int BAWIDTH = BA_W,
  parameter int CHWIDTH = 5,
  parameter int ADDRWIDTH = 17,
  parameter int BEATS = 8,
  localparam int BANKGROUPS = 2 ** BGWIDTH,
  localparam int BANKSPERGROUP = 2 ** BAWIDTH,
  localparam int NBANKS = BANKGROUPS * BANKSPERGROUP,
  localparam int BW = BGWIDTH + BAWIDTH,
  localparam int BEATW = $clog2(BEATS)
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [NBANKS-1:0]                        req,
  input  logic [NBANKS-1:0]                        req_wb,
  input  logic [NBANKS-1:0][ADDRWIDTH-1:0]         req_row,
  input  logic [NBANKS-1:0][ADDRWIDTH-1:0]         req_evict_row,
  input  logic [NBANKS-1:0][CHWIDTH-1:0]           req_slot,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0] sync,
  output logic                                     busy,
  output logic                                     mem_valid,
  input  logic                                     mem_ready,
  output logic                                     mem_we,
  output logic [BW-1:0]                            mem_bank,
  output logic [ADDRWIDTH-1:0]                     mem_row,
  output logic [CHWIDTH-1:0]                       mem_slot,
  output logic [BEATW-1:0]                         mem_beat
);
  sync_state_t state;
  logic [ADDRWIDTH-1:0] fill_row;
  logic [BW-1:0] gnt;
  logic gnt_valid;
  rr_arbiter #(.N(NBANKS)) u_arb (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .mask_en(state == HOLD),
    .mask_idx(mem_bank),
    .advance(state == DONE),
    .adv_idx(mem_bank),
    .gnt_valid(gnt_valid),
    .gnt(gnt)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      busy <= 1'b0;
      mem_valid <= 1'b0;
      mem_we <= 1'b0;
      mem_bank <= '0;
      mem_row <= '0;
      mem_slot <= '0;
      mem_beat <= '0;
      fill_row <= '0;
      sync <= '0;
    end else begin
      sync <= '0;
      case (state)
        IDLE, HOLD: begin
          busy <= gnt_valid;
          state <= !gnt_valid ? IDLE : req_wb[gnt] ? WB : FILL;
          if (gnt_valid) begin
            mem_valid <= 1'b1;
            mem_we <= req_wb[gnt];
            mem_bank <= gnt;
            mem_row <= req_wb[gnt] ? req_evict_row[gnt] : req_row[gnt];
            fill_row <= req_row[gnt];
            mem_slot <= req_slot[gnt];
            mem_beat <= '0;
          end
        end
        WB, FILL: if (mem_ready) begin
          mem_beat <= mem_beat + 1'b1;
          // Beat counter wraps to 0 on the last beat, ready for the fill phase
          if (mem_beat == BEATW'(BEATS - 1)) begin
            state <= state == WB ? FILL : DONE;
            mem_we <= 1'b0;
            mem_row <= fill_row;
            mem_valid <= state == WB;
            sync <= state == WB ? '0 : NBANKS'(1) << mem_bank;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end
endmodule
